// File: rtl/buf_rd_arbiter.sv
// ---------------------------------------------------------------------------
// buf_rd_arbiter
//
// Shares one buffer read port between two requesters. Each cycle at most one
// request is granted. The winning address goes out on the buffer port one
// cycle later. The owner of every issued read is queued in an owner FIFO, so
// the in-order read data can be routed back to the requester that asked for it.
//
// Arbitration works as follows:
//   - A lone requester always wins.
//   - When both requesters are active, the last owner keeps the port until it
//     has taken MAX_BURST consecutive grants. The other requester then wins.
//
// Ports:
//   aclk, areset            clock; asynchronous active-high reset
//   reqN_avalid, reqN_addr  request N (N=0,1); held until granted
//   reqN_gnt                combinational grant for request N
//   reqN_valid, reqN_data   registered read return for requester N
//   buf_avalid, buf_addr    registered read strobe/address to the buffer
//   buf_valid, buf_data     in-order read return from the buffer
//   outstanding             issued reads not yet returned
//   err_orphan              sticky: a buffer return arrived with nothing in flight
// ---------------------------------------------------------------------------
module buf_rd_arbiter #(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 11,
  parameter int MAX_BURST  = 16,
  parameter int TAG_DEPTH  = 8
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic                         req0_avalid,
  input  logic [ADDR_WIDTH-1:0]        req0_addr,
  output logic                         req0_gnt,
  output logic                         req0_valid,
  output logic [DATA_WIDTH-1:0]        req0_data,
  input  logic                         req1_avalid,
  input  logic [ADDR_WIDTH-1:0]        req1_addr,
  output logic                         req1_gnt,
  output logic                         req1_valid,
  output logic [DATA_WIDTH-1:0]        req1_data,
  output logic                         buf_avalid,
  output logic [ADDR_WIDTH-1:0]        buf_addr,
  input  logic                         buf_valid,
  input  logic [DATA_WIDTH-1:0]        buf_data,
  output logic [$clog2(TAG_DEPTH):0]   outstanding,
  output logic                         err_orphan
);

  localparam int PTR_W   = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CNT_W   = $clog2(TAG_DEPTH) + 1;
  localparam int BURST_W = $clog2(MAX_BURST) + 1;

  localparam logic [CNT_W-1:0]   FULL_LVL  = CNT_W'(TAG_DEPTH);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);
  localparam logic [PTR_W-1:0]   PTR_LAST  = PTR_W'(TAG_DEPTH - 1);

  // Advance a FIFO pointer, wrapping at the last slot.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    logic [PTR_W-1:0] nxt;
    if (ptr == PTR_LAST) begin
      nxt = {PTR_W{1'b0}};
    end else begin
      nxt = ptr + PTR_W'(1);
    end
    return nxt;
  endfunction

  // Owner FIFO: one bit per outstanding read (0 = req0, 1 = req1).
  logic [TAG_DEPTH-1:0]  owner_mem_r;
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [CNT_W-1:0]      count_r;

  // Arbiter history.
  logic                  last_owner_r;
  logic [BURST_W-1:0]    burst_cnt_r;

  // Registered outputs.
  logic                  buf_avalid_r;
  logic [ADDR_WIDTH-1:0] buf_addr_r;
  logic                  valid0_r;
  logic                  valid1_r;
  logic [DATA_WIDTH-1:0] data0_r;
  logic [DATA_WIDTH-1:0] data1_r;
  logic                  err_orphan_r;

  // Combinational decisions.
  logic                  pop_s;
  logic                  room_s;
  logic                  pick_one_s;
  logic                  gnt0_s;
  logic                  gnt1_s;
  logic                  gnt_any_s;
  logic                  gnt_owner_s;
  logic [ADDR_WIDTH-1:0] gnt_addr_s;
  logic                  pop_owner_s;

  // Grant decision. A pop in this cycle frees a slot, so a full FIFO can still accept a grant.
  always_comb begin
    pop_s       = buf_valid && (count_r != {CNT_W{1'b0}});
    room_s      = (count_r != FULL_LVL) || pop_s;
    // Once the burst counter reaches MAX_BURST, the other requester wins a contested cycle.
    pick_one_s  = (burst_cnt_r >= BURST_MAX) ? ~last_owner_r : last_owner_r;
    gnt0_s      = 1'b0;
    gnt1_s      = 1'b0;
    if (!areset && room_s) begin
      case ({req1_avalid, req0_avalid})
        2'b01:   gnt0_s = 1'b1;
        2'b10:   gnt1_s = 1'b1;
        2'b11: begin
          gnt0_s = ~pick_one_s;
          gnt1_s = pick_one_s;
        end
        default: begin
          gnt0_s = 1'b0;
          gnt1_s = 1'b0;
        end
      endcase
    end else begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end
    gnt_any_s   = gnt0_s | gnt1_s;
    gnt_owner_s = gnt1_s;
    gnt_addr_s  = gnt1_s ? req1_addr : req0_addr;
    pop_owner_s = owner_mem_r[rd_ptr_r];
  end

  // Owner FIFO storage, pointers and occupancy.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      owner_mem_r <= {TAG_DEPTH{1'b0}};
      wr_ptr_r    <= {PTR_W{1'b0}};
      rd_ptr_r    <= {PTR_W{1'b0}};
      count_r     <= {CNT_W{1'b0}};
    end else begin
      if (gnt_any_s) begin
        owner_mem_r[wr_ptr_r] <= gnt_owner_s;
        wr_ptr_r              <= next_ptr(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= next_ptr(rd_ptr_r);
      end
      case ({gnt_any_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Last-owner pointer and burst counter. The counter saturates so that a long solo run cannot wrap it.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      last_owner_r <= 1'b0;
      burst_cnt_r  <= {BURST_W{1'b0}};
    end else if (gnt_any_s) begin
      if (gnt_owner_s == last_owner_r) begin
        burst_cnt_r <= (burst_cnt_r >= BURST_MAX) ? BURST_MAX : burst_cnt_r + BURST_W'(1);
      end else begin
        last_owner_r <= gnt_owner_s;
        burst_cnt_r  <= BURST_W'(1);
      end
    end else begin
      burst_cnt_r <= {BURST_W{1'b0}};
    end
  end

  // Buffer read request, issued one cycle after the grant. The address holds when idle.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      buf_avalid_r <= 1'b0;
      buf_addr_r   <= {ADDR_WIDTH{1'b0}};
    end else begin
      buf_avalid_r <= gnt_any_s;
      if (gnt_any_s) begin
        buf_addr_r <= gnt_addr_s;
      end
    end
  end

  // Return routing to the FIFO-head owner. Data registers hold between returns.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      valid0_r <= 1'b0;
      valid1_r <= 1'b0;
      data0_r  <= {DATA_WIDTH{1'b0}};
      data1_r  <= {DATA_WIDTH{1'b0}};
    end else begin
      valid0_r <= pop_s && !pop_owner_s;
      valid1_r <= pop_s && pop_owner_s;
      if (pop_s && !pop_owner_s) begin
        data0_r <= buf_data;
      end
      if (pop_s && pop_owner_s) begin
        data1_r <= buf_data;
      end
    end
  end

  // Sticky orphan flag: a buffer return arrived with nothing in flight.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      err_orphan_r <= 1'b0;
    end else if (buf_valid && (count_r == {CNT_W{1'b0}})) begin
      err_orphan_r <= 1'b1;
    end
  end

  assign req0_gnt    = gnt0_s;
  assign req1_gnt    = gnt1_s;
  assign req0_valid  = valid0_r;
  assign req1_valid  = valid1_r;
  assign req0_data   = data0_r;
  assign req1_data   = data1_r;
  assign buf_avalid  = buf_avalid_r;
  assign buf_addr    = buf_addr_r;
  assign outstanding = count_r;
  assign err_orphan  = err_orphan_r;

endmodule

// File: tb/tb_buf_rd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_buf_rd_arbiter
//
// Drives buf_rd_arbiter with directed scenarios and a randomized phase. A
// model of the arbitration rules and an owner queue predicts every output.
// The model is compared with the DUT on each falling clock edge. Literal
// expectations for the key scenarios pin the model itself.
// ---------------------------------------------------------------------------
module tb_buf_rd_arbiter;
  localparam int DW = 512;
  localparam int AW = 11;
  localparam int MB = 16;
  localparam int TD = 8;

  logic              aclk        = 1'b0;
  logic              areset      = 1'b1;
  logic              req0_avalid = 1'b0;
  logic              req1_avalid = 1'b0;
  logic [AW-1:0]     req0_addr   = '0;
  logic [AW-1:0]     req1_addr   = '0;
  logic              req0_gnt, req1_gnt, req0_valid, req1_valid;
  logic [DW-1:0]     req0_data, req1_data;
  logic              buf_avalid;
  logic [AW-1:0]     buf_addr;
  logic              buf_valid   = 1'b0;
  logic [DW-1:0]     buf_data    = '0;
  logic [$clog2(TD):0] outstanding;
  logic              err_orphan;

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  buf_rd_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(MB), .TAG_DEPTH(TD)
  ) dut (
    .aclk(aclk), .areset(areset),
    .req0_avalid(req0_avalid), .req0_addr(req0_addr), .req0_gnt(req0_gnt),
    .req0_valid(req0_valid), .req0_data(req0_data),
    .req1_avalid(req1_avalid), .req1_addr(req1_addr), .req1_gnt(req1_gnt),
    .req1_valid(req1_valid), .req1_data(req1_data),
    .buf_avalid(buf_avalid), .buf_addr(buf_addr),
    .buf_valid(buf_valid), .buf_data(buf_data),
    .outstanding(outstanding), .err_orphan(err_orphan)
  );

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference model state
  int            m_q[$];
  int            m_last = 0;
  int            m_cnt  = 0;
  bit            m_av   = 1'b0;
  logic [AW-1:0] m_addr = '0;
  bit            m_v0   = 1'b0;
  bit            m_v1   = 1'b0;
  logic [DW-1:0] m_d0   = '0;
  logic [DW-1:0] m_d1   = '0;
  bit            m_err  = 1'b0;
  bit            g0_seen = 1'b0;
  bit            g1_seen = 1'b0;
  int            gseq[$];
  int            gcyc[$];
  int            aseq[$];
  int            vseq[$];
  int            ncyc = 0;

  // Compare process: predict and check every output on the falling edge
  initial begin : compare
    bit mg0, mg1, pop, room;
    int who, k;
    forever begin
      @(negedge aclk);
      ncyc++;
      mg0 = 1'b0;
      mg1 = 1'b0;
      if (areset) begin
        m_q.delete();
        m_last = 0; m_cnt = 0; m_av = 1'b0; m_addr = '0;
        m_v0 = 1'b0; m_v1 = 1'b0; m_d0 = '0; m_d1 = '0; m_err = 1'b0;
      end else begin
        pop  = buf_valid && (m_q.size() > 0);
        room = (m_q.size() < TD) || pop;
        if (room && req0_avalid && req1_avalid) begin
          who = (m_cnt >= MB) ? 1 - m_last : m_last;
          mg0 = (who == 0);
          mg1 = (who == 1);
        end else if (room) begin
          mg0 = req0_avalid;
          mg1 = req1_avalid;
        end
      end
      chk("gnt0", req0_gnt, mg0);
      chk("gnt1", req1_gnt, mg1);
      chk("buf_avalid", buf_avalid, m_av);
      chk("buf_addr", buf_addr, m_addr);
      chk("valid0", req0_valid, m_v0);
      chk("valid1", req1_valid, m_v1);
      chk("data0", req0_data, m_d0);
      chk("data1", req1_data, m_d1);
      chk("outstanding", outstanding, m_q.size());
      chk("err_orphan", err_orphan, m_err);
      if (!areset) begin
        if (buf_valid && m_q.size() == 0) m_err = 1'b1;
        m_v0 = 1'b0;
        m_v1 = 1'b0;
        if (pop) begin
          k = m_q.pop_front();
          vseq.push_back(k);
          if (k == 0) begin m_v0 = 1'b1; m_d0 = buf_data; end
          else begin m_v1 = 1'b1; m_d1 = buf_data; end
        end
        if (mg0 || mg1) begin
          who = mg1 ? 1 : 0;
          m_q.push_back(who);
          gseq.push_back(who);
          gcyc.push_back(ncyc);
          m_addr = mg1 ? req1_addr : req0_addr;
          aseq.push_back(int'(m_addr));
          m_av = 1'b1;
          if (who == m_last) m_cnt = (m_cnt < MB) ? m_cnt + 1 : MB;
          else begin m_last = who; m_cnt = 1; end
        end else begin
          m_av  = 1'b0;
          m_cnt = 0;
        end
      end
      g0_seen = mg0;
      g1_seen = mg1;
    end
  end

  // Buffer environment: in-order returns after a configurable latency
  int pend_due[$];
  int cyc   = 0;
  int lat   = 1;
  bit stall = 1'b0;

  task automatic tick();
    @(posedge aclk);
    #1;
    cyc++;
    if (buf_avalid) pend_due.push_back(cyc + lat);
    buf_valid = 1'b0;
    for (int i = 0; i < DW / 32; i++) buf_data[i*32 +: 32] = $urandom();
    if (!stall && pend_due.size() > 0 && pend_due[0] <= cyc) begin
      void'(pend_due.pop_front());
      buf_valid = 1'b1;
    end
  endtask

  task automatic issue(input int who, input int addr, input string nm);
    int n;
    bit seen;
    n = 0;
    if (who == 0) begin req0_avalid = 1'b1; req0_addr = AW'(addr); end
    else begin req1_avalid = 1'b1; req1_addr = AW'(addr); end
    do begin
      tick();
      n++;
      seen = (who == 0) ? g0_seen : g1_seen;
    end while (!seen && n < 100);
    chk(nm, seen, 1'b1);
    if (who == 0) req0_avalid = 1'b0;
    else req1_avalid = 1'b0;
  endtask

  task automatic clr();
    gseq.delete(); gcyc.delete(); aseq.delete(); vseq.delete();
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : driver
    int n0, n1, p0, p1;
    // Reset with both requests high: no grants may appear
    req0_avalid = 1'b1; req1_avalid = 1'b1;
    req0_addr = AW'(3); req1_addr = AW'(4);
    repeat (3) tick();
    chk("reset_outstanding", outstanding, 0);
    chk("reset_gnts", {req0_gnt, req1_gnt}, 2'b00);
    areset = 1'b0;
    req0_avalid = 1'b0; req1_avalid = 1'b0;
    repeat (2) tick();

    // Lone req0, addresses 5,6,7, latency 2
    clr(); lat = 2;
    for (int a = 5; a <= 7; a++) issue(0, a, "p035_grant");
    repeat (10) tick();
    chk("p035_ngrants", gseq.size(), 3);
    if (gseq.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        chk("p035_addr", aseq[i], 5 + i);
        chk("p035_consecutive", gcyc[i] - gcyc[0], i);
      end
    end
    n0 = 0; n1 = 0;
    foreach (vseq[i]) if (vseq[i] == 0) n0++; else n1++;
    chk("p035_valid0_count", n0, 3);
    chk("p035_valid1_count", n1, 0);

    // Both requesters continuously active: 16/16 alternation
    clr(); lat = 1;
    req0_avalid = 1'b1; req1_avalid = 1'b1;
    req0_addr = AW'($urandom()); req1_addr = AW'($urandom());
    repeat (64) begin
      tick();
      if (g0_seen) req0_addr = AW'($urandom());
      if (g1_seen) req1_addr = AW'($urandom());
    end
    req0_avalid = 1'b0; req1_avalid = 1'b0;
    repeat (10) tick();
    chk("p036_ngrants", gseq.size(), 64);
    if (gseq.size() == 64) begin
      for (int i = 0; i < 64; i++) chk($sformatf("p036_g%0d", i), gseq[i], (i / 16) % 2);
    end

    // Buffer stalled: FIFO fills at TAG_DEPTH, then a pop lets one grant through
    clr(); stall = 1'b1;
    req0_avalid = 1'b1; req0_addr = AW'($urandom());
    repeat (12) begin
      tick();
      if (g0_seen) req0_addr = AW'($urandom());
    end
    chk("p037_grants_when_full", gseq.size(), 8);
    chk("p037_outstanding_full", outstanding, 8);
    chk("p037_no_gnt_full", req0_gnt, 1'b0);
    stall = 1'b0;
    tick();
    #1;
    chk("p037_gnt_with_pop", req0_gnt, 1'b1);
    tick();
    req0_avalid = 1'b0;
    repeat (30) tick();
    chk("p037_total_grants", gseq.size(), 9);

    // Interleaved owners, latency 3: returns routed in issue order
    clr(); lat = 3;
    issue(0, 'h10, "p038_grant0");
    issue(1, 'h20, "p038_grant1");
    issue(0, 'h30, "p038_grant2");
    repeat (15) tick();
    chk("p038_nreturns", vseq.size(), 3);
    if (vseq.size() == 3 && aseq.size() == 3) begin
      chk("p038_owner0", vseq[0], 0);
      chk("p038_owner1", vseq[1], 1);
      chk("p038_owner2", vseq[2], 0);
      chk("p038_addr0", aseq[0], 'h10);
      chk("p038_addr1", aseq[1], 'h20);
      chk("p038_addr2", aseq[2], 'h30);
    end

    // Randomized traffic with varying load, latency and stalls
    p0 = 50; p1 = 50;
    for (int c = 0; c < 1500; c++) begin
      if (c % 200 == 0) begin
        p0  = $urandom_range(0, 100);
        p1  = $urandom_range(0, 100);
        lat = $urandom_range(1, 4);
      end
      if ($urandom_range(0, 29) == 0) stall = ~stall;
      if (!req0_avalid || g0_seen) begin
        req0_avalid = ($urandom_range(0, 99) < p0);
        req0_addr   = AW'($urandom());
      end
      if (!req1_avalid || g1_seen) begin
        req1_avalid = ($urandom_range(0, 99) < p1);
        req1_addr   = AW'($urandom());
      end
      tick();
    end
    req0_avalid = 1'b0; req1_avalid = 1'b0; stall = 1'b0;
    repeat (40) tick();
    chk("rand_drained", outstanding, 0);
    chk("rand_no_orphan", err_orphan, 1'b0);

    // Reset with 3 reads in flight; late returns are orphans
    stall = 1'b1; lat = 1;
    for (int i = 0; i < 3; i++) issue(0, 'h40 + i, "p039_grant");
    repeat (3) tick();
    chk("p039_outstanding_pre", outstanding, 3);
    areset = 1'b1;
    repeat (2) tick();
    areset = 1'b0;
    tick();
    clr();
    stall = 1'b0;
    repeat (10) tick();
    chk("p039_no_valids", vseq.size(), 0);
    chk("p039_err_orphan", err_orphan, 1'b1);
    chk("p039_outstanding", outstanding, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
